dma_ctrl: RTL and testbench
===========================

# dma_ctrl

CPU-facing command front-end for the BrainForge8 DMA engine. Exposes an 8-register byte-wide window through which the CPU stages transfer descriptors (SRC, DST, LEN, INC), queues them, and issues them one at a time to the DMA engine via a single-cycle RUN pulse. It watches the engine's BUSY/TRIG_DMAD/TRIG_DMAE outputs and folds completion, error, overflow and abort events into sticky flags with one interrupt line.

## Interface
- DEPTH, 4, descriptor queue entries (power of two, max 4) when DMA_CTRL_FIFO_EN is defined; forced to 1 otherwise
- CLK  in  1  system clock
- RST  in  1  asynchronous active-low reset
- CS  in  1  register window select
- WE  in  1  write strobe (1=write, 0=read), qualified by CS
- ADDR  in  3  register index
- DIN  in  8  CPU write data
- DOUT  out  8  CPU read data, combinational from ADDR
- IRQ  out  1  interrupt, registered
- RUN  out  1  one-cycle start/cancel pulse to DMA
- SRC  out  16  active source address
- DST  out  16  active destination address
- LEN  out  8  active byte count
- INC  out  8  active destination increment
- BUSY  in  1  DMA busy
- TRIG_DMAD  in  1  DMA done pulse
- TRIG_DMAE  in  1  DMA error pulse

## Operation
- Register map: 0 SRC_L, 1 SRC_H, 2 DST_L, 3 DST_H, 4 LEN, 5 INC (staging, R/W); 6 CMD/STATUS; 7 FLAGS.
- CMD write: bit0 PUSH, bit1 ABORT (self-clearing), bit7 IE (stored).
- STATUS read: bit7 IE, bit6 ACTIVE (state≠IDLE), bits5:3 queue count, bit2 empty, bit1 full, bit0 BUSY.
- FLAGS: bit0 DONE, bit1 ERR, bit2 OVF, bit3 ABT; sticky, write-1-to-clear; bits7:4 read 0.
- PUSH: copies staging into queue tail; staging keeps its values. Push when full → dropped, OVF set. Push with staging LEN=0 → dropped, ERR set.
- IRQ = IE & |FLAGS[3:0], registered.
- FSM states: IDLE, ISSUE, WAIT, RUNNING.
  - IDLE: queue non-empty and BUSY=0 → pop head into active SRC/DST/LEN/INC, go ISSUE.
  - ISSUE: RUN=1 for exactly this cycle; go WAIT.
  - WAIT: BUSY=1 → RUNNING; BUSY still 0 after 2 cycles in WAIT → ERR set, IDLE.
  - RUNNING: TRIG_DMAD → DONE set; TRIG_DMAE → ERR set; BUSY=0 → IDLE.
- ABORT in WAIT/RUNNING: queue flushed, active LEN forced 0, RUN pulsed one cycle (engine cancel), ABT set, FSM → RUNNING awaiting BUSY=0. ABORT in IDLE/ISSUE: queue flushed, ABT set, no RUN (pending ISSUE still completes its RUN).
- TRIG_DMAE sets ERR in any state.

## Timing
- Reset: RUN=0, SRC=DST=0, LEN=0, INC=0, IRQ=0, FSM=IDLE, queue empty, FLAGS=0, IE=0, staging all 0 except INC=0x01.
- Register writes take effect on the CLK edge with CS&WE; reads combinational.
- Push→RUN latency with empty queue and idle engine: PUSH edge (cycle 0), pop (cycle 1), RUN high cycle 2.
- SRC/DST/LEN/INC stable from RUN cycle until next pop.
- Back-to-back descriptors: next RUN no earlier than 2 cycles after BUSY falls.
- Simultaneous: push and pop same cycle when full → accepted, no OVF; ABORT with PUSH → abort wins, push dropped, no OVF; flag set and W1C same cycle → set wins.
- Queue pointers wrap modulo DEPTH; count saturates at DEPTH.
- Reset asserted mid-transfer: all state cleared immediately; RUN deasserts asynchronously.

## Configuration
- DMA_CTRL_FIFO_EN defined: DEPTH-entry circular queue as above.
- Undefined: single descriptor slot; full = slot occupied; count reads 0/1; all other behaviour identical.

## Test plan
- Stage SRC=0x1200, DST=0x3400, LEN=3, INC=1, PUSH, model BUSY high 4 cycles then TRIG_DMAD → one RUN pulse 2 cycles after PUSH with outputs matching, DONE=1, IRQ=1 only when IE=1.
- Push 5 descriptors with engine stalled BUSY=1 (FIFO_EN) → count=4, full=1, OVF=1; release → 4 RUNs in push order.
- Push LEN=0 → no queue entry, ERR=1, count unchanged.
- ABORT while RUNNING with 2 queued → one RUN with LEN=0, queue empty, ABT=1, FSM IDLE after BUSY falls.
- Engine never raises BUSY after RUN → ERR=1 within 3 cycles, FSM IDLE.
- Write FLAGS=0x0F on same cycle as TRIG_DMAD → DONE stays 1, others cleared; async RST mid-RUNNING → all outputs at reset values.

Source files
------------

// File: rtl/dma_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dma_ctrl
// Brief    : CPU register window, descriptor queue and issue FSM that drives
//            the BrainForge8 DMA engine. Define DMA_CTRL_FIFO_EN for a
//            DEPTH-entry descriptor queue; without it a single slot is used.
// Revision : 1.0 - initial release
// ============================================================================
module dma_ctrl #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CS,
    input  logic        WE,
    input  logic [2:0]  ADDR,
    input  logic [7:0]  DIN,
    output logic [7:0]  DOUT,
    output logic        IRQ,
    output logic        RUN,
    output logic [15:0] SRC,
    output logic [15:0] DST,
    output logic [7:0]  LEN,
    output logic [7:0]  INC,
    input  logic        BUSY,
    input  logic        TRIG_DMAD,
    input  logic        TRIG_DMAE
);

`ifdef DMA_CTRL_FIFO_EN
    localparam int unsigned c_qdepth = DEPTH;
`else
    // One descriptor slot; DEPTH only matters when the queue is enabled.
    localparam int unsigned c_qdepth = (DEPTH > 0) ? 1 : 1;
`endif
    localparam int unsigned     c_pw       = (c_qdepth > 1) ? $clog2(c_qdepth) : 1;
    localparam logic [2:0]      c_cnt_full = 3'(c_qdepth);
    localparam logic [c_pw-1:0] c_ptr_last = c_pw'(c_qdepth - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RUNNING = 2'd3
    } state_t;

    typedef struct packed {
        logic [15:0] src;
        logic [15:0] dst;
        logic [7:0]  len;
        logic [7:0]  inc;
    } desc_t;

    state_t          state_q,   state_d;
    logic            wait_cnt_q, wait_cnt_d;
    logic            run_q,     run_d;
    desc_t           act_q,     act_d;
    desc_t           stg_q,     stg_d;
    desc_t           fifo_q [c_qdepth];
    desc_t           fifo_d [c_qdepth];
    logic [c_pw-1:0] rd_ptr_q,  rd_ptr_d;
    logic [c_pw-1:0] wr_ptr_q,  wr_ptr_d;
    logic [2:0]      count_q,   count_d;
    logic [3:0]      flags_q,   flags_d;
    logic            ie_q,      ie_d;
    logic            irq_q,     irq_d;

    logic       w_wr;
    logic       w_cmd_wr;
    logic       w_abort;
    logic       w_cancel;
    logic       w_push_req;
    logic       w_push_len0;
    logic       w_push_ovf;
    logic       w_push_ok;
    logic       w_pop;
    logic       w_empty;
    logic       w_full;
    logic       w_timeout;
    logic [3:0] w_flag_set;
    logic [3:0] w_flag_clr;
    logic [7:0] w_status;

    function automatic logic [c_pw-1:0] f_ptr_inc(input logic [c_pw-1:0] p);
        return (p == c_ptr_last) ? '0 : p + 1'b1;
    endfunction

    assign w_wr       = CS & WE;
    assign w_cmd_wr   = w_wr & (ADDR == 3'd6);
    assign w_abort    = w_cmd_wr & DIN[1];
    assign w_push_req = w_cmd_wr & DIN[0] & ~DIN[1];
    assign w_empty    = (count_q == 3'd0);
    assign w_full     = (count_q == c_cnt_full);
    assign w_cancel   = w_abort & ((state_q == ST_WAIT) | (state_q == ST_RUNNING));

    // Abort takes priority over a pop so an aborted IDLE never launches.
    assign w_pop       = (state_q == ST_IDLE) & ~w_empty & ~BUSY & ~w_abort;
    assign w_push_len0 = w_push_req & (stg_q.len == 8'd0);
    assign w_push_ovf  = w_push_req & ~w_push_len0 & w_full & ~w_pop;
    assign w_push_ok   = w_push_req & ~w_push_len0 & (~w_full | w_pop);

    always_comb begin
        stg_d = stg_q;
        if (w_wr) begin
            case (ADDR)
                3'd0:    stg_d.src[7:0]  = DIN;
                3'd1:    stg_d.src[15:8] = DIN;
                3'd2:    stg_d.dst[7:0]  = DIN;
                3'd3:    stg_d.dst[15:8] = DIN;
                3'd4:    stg_d.len       = DIN;
                3'd5:    stg_d.inc       = DIN;
                default: ;
            endcase
        end
    end

    always_comb begin
        fifo_d   = fifo_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (w_abort) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = 3'd0;
        end else begin
            if (w_push_ok) begin
                fifo_d[wr_ptr_q] = stg_q;
                wr_ptr_d         = f_ptr_inc(wr_ptr_q);
            end
            if (w_pop) begin
                rd_ptr_d = f_ptr_inc(rd_ptr_q);
            end
            case ({w_push_ok, w_pop})
                2'b10:   count_d = count_q + 3'd1;
                2'b01:   count_d = count_q - 3'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        run_d      = 1'b0;
        act_d      = act_q;
        w_timeout  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_pop) begin
                    act_d   = fifo_q[rd_ptr_q];
                    run_d   = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wait_cnt_d = 1'b0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_cancel) begin
                    act_d.len = 8'd0;
                    run_d     = 1'b1;
                    state_d   = ST_RUNNING;
                end else if (BUSY) begin
                    state_d = ST_RUNNING;
                end else if (wait_cnt_q) begin
                    w_timeout = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    wait_cnt_d = 1'b1;
                end
            end
            ST_RUNNING: begin
                // A zero-length RUN tells the engine to cancel; then wait for it to drop BUSY.
                if (w_cancel) begin
                    act_d.len = 8'd0;
                    run_d     = 1'b1;
                end else if (!BUSY) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        w_flag_set[0] = (state_q == ST_RUNNING) & TRIG_DMAD;
        w_flag_set[1] = TRIG_DMAE | w_push_len0 | w_timeout;
        w_flag_set[2] = w_push_ovf;
        w_flag_set[3] = w_abort;
        w_flag_clr    = (w_wr && (ADDR == 3'd7)) ? DIN[3:0] : 4'd0;
        flags_d       = (flags_q & ~w_flag_clr) | w_flag_set;
        ie_d          = w_cmd_wr ? DIN[7] : ie_q;
        irq_d         = ie_q & (|flags_q);
    end

    assign w_status = {ie_q, (state_q != ST_IDLE), count_q, w_empty, w_full, BUSY};

    always_comb begin
        DOUT = 8'd0;
        case (ADDR)
            3'd0:    DOUT = stg_q.src[7:0];
            3'd1:    DOUT = stg_q.src[15:8];
            3'd2:    DOUT = stg_q.dst[7:0];
            3'd3:    DOUT = stg_q.dst[15:8];
            3'd4:    DOUT = stg_q.len;
            3'd5:    DOUT = stg_q.inc;
            3'd6:    DOUT = w_status;
            3'd7:    DOUT = {4'd0, flags_q};
            default: DOUT = 8'd0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 1'b0;
            run_q      <= 1'b0;
            act_q      <= '0;
            stg_q      <= '{src: 16'd0, dst: 16'd0, len: 8'd0, inc: 8'h01};
            fifo_q     <= '{default: '0};
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= 3'd0;
            flags_q    <= 4'd0;
            ie_q       <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            run_q      <= run_d;
            act_q      <= act_d;
            stg_q      <= stg_d;
            fifo_q     <= fifo_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            flags_q    <= flags_d;
            ie_q       <= ie_d;
            irq_q      <= irq_d;
        end
    end

    assign RUN = run_q;
    assign IRQ = irq_q;
    assign SRC = act_q.src;
    assign DST = act_q.dst;
    assign LEN = act_q.len;
    assign INC = act_q.inc;

endmodule
`default_nettype wire

// File: tb/tb_dma_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// tb_dma_ctrl: register-window vector table, directed corner sequences and
// randomized stalled-burst rounds scored against a descriptor-queue model.
module tb_dma_ctrl;

`ifdef DMA_CTRL_FIFO_EN
    localparam int MD = 4;
`else
    localparam int MD = 1;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        CS = 1'b0;
    logic        WE = 1'b0;
    logic [2:0]  ADDR = 3'd0;
    logic [7:0]  DIN = 8'd0;
    logic        BUSY = 1'b0;
    logic        TRIG_DMAD = 1'b0;
    logic        TRIG_DMAE = 1'b0;
    logic [7:0]  DOUT;
    logic        IRQ;
    logic        RUN;
    logic [15:0] SRC;
    logic [15:0] DST;
    logic [7:0]  LEN;
    logic [7:0]  INC;

    int n_checks = 0;
    int n_fail   = 0;
    int run_cnt  = 0;

    logic [7:0]  stg [0:5];
    logic [47:0] q_m [$];

    typedef struct packed {
        logic       wr;
        logic [2:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;
    vec_t vt [14];

    dma_ctrl #(.DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .CS(CS), .WE(WE), .ADDR(ADDR), .DIN(DIN),
        .DOUT(DOUT), .IRQ(IRQ), .RUN(RUN), .SRC(SRC), .DST(DST), .LEN(LEN),
        .INC(INC), .BUSY(BUSY), .TRIG_DMAD(TRIG_DMAD), .TRIG_DMAE(TRIG_DMAE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (RUN) run_cnt <= run_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        CS = 1'b1; WE = 1'b1; ADDR = a; DIN = d;
        if (a < 3'd6) stg[a] = d;
        tick();
        CS = 1'b0; WE = 1'b0; DIN = 8'd0;
    endtask

    task automatic chk_reg(input string name, input logic [2:0] a, input logic [7:0] exp);
        ADDR = a;
        #1;
        check(name, 64'(DOUT), 64'(exp));
    endtask

    function automatic logic [47:0] stg_desc();
        return {stg[1], stg[0], stg[3], stg[2], stg[4], stg[5]};
    endfunction

    function automatic logic [7:0] status_m(input logic ie, input logic act, input int cnt, input logic busy);
        return {ie, act, 3'(cnt), (cnt == 0), (cnt == MD), busy};
    endfunction

    task automatic wait_run();
        for (int i = 0; i < 20; i++) begin
            if (RUN) break;
            tick();
        end
        check("run_seen", 64'(RUN), 64'd1);
    endtask

    // Engine model: BUSY for k cycles starting on the RUN cycle, done pulse on the last one.
    task automatic serve(input logic [47:0] exp_d, input int k);
        wait_run();
        check("run_desc", 64'({SRC, DST, LEN, INC}), 64'(exp_d));
        BUSY = 1'b1;
        for (int c = 1; c < k; c++) begin
            tick();
            if (c == k - 1) TRIG_DMAD = 1'b1;
        end
        tick();
        TRIG_DMAD = 1'b0;
        BUSY = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: run_cnt=%0d checks=%0d", run_cnt, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        stg = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        vt = '{
            '{1'b0, 3'd0, 8'h00, 8'h00}, '{1'b0, 3'd5, 8'h00, 8'h01},
            '{1'b0, 3'd6, 8'h00, 8'h04}, '{1'b0, 3'd7, 8'h00, 8'h00},
            '{1'b1, 3'd0, 8'hA5, 8'hA5}, '{1'b1, 3'd1, 8'h5A, 8'h5A},
            '{1'b1, 3'd2, 8'h3C, 8'h3C}, '{1'b1, 3'd3, 8'hC3, 8'hC3},
            '{1'b1, 3'd4, 8'h7E, 8'h7E}, '{1'b1, 3'd5, 8'h81, 8'h81},
            '{1'b0, 3'd0, 8'h00, 8'hA5}, '{1'b1, 3'd6, 8'h80, 8'h84},
            '{1'b1, 3'd6, 8'h00, 8'h04}, '{1'b1, 3'd7, 8'hFF, 8'h00}
        };

        repeat (3) @(posedge CLK);
        #1;
        check("rst_run", 64'(RUN), 64'd0);
        check("rst_irq", 64'(IRQ), 64'd0);
        check("rst_desc", 64'({SRC, DST, LEN, INC}), 64'd0);
        RST = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            if (vt[i].wr) wr(vt[i].a, vt[i].d);
            chk_reg($sformatf("vec%0d", i), vt[i].a, vt[i].exp);
        end

        // Basic transfer: RUN exactly two cycles after the PUSH write cycle.
        wr(3'd0, 8'h00); wr(3'd1, 8'h12); wr(3'd2, 8'h00);
        wr(3'd3, 8'h34); wr(3'd4, 8'h03); wr(3'd5, 8'h01);
        n0 = run_cnt;
        wr(3'd6, 8'h01);
        check("lat_c1", 64'(RUN), 64'd0);
        tick();
        check("lat_c2", 64'(RUN), 64'd1);
        serve(48'h1200_3400_03_01, 4);
        repeat (3) tick();
        check("basic_one_run", 64'(run_cnt - n0), 64'd1);
        chk_reg("basic_done", 3'd7, 8'h01);
        check("basic_irq_ie0", 64'(IRQ), 64'd0);
        wr(3'd6, 8'h80);
        tick();
        check("basic_irq_ie1", 64'(IRQ), 64'd1);
        wr(3'd7, 8'h0F);
        tick();
        check("basic_irq_clr", 64'(IRQ), 64'd0);
        chk_reg("basic_flags_clr", 3'd7, 8'h00);
        wr(3'd6, 8'h00);

        // Zero-length push is dropped with ERR.
        wr(3'd4, 8'h00);
        n0 = run_cnt;
        wr(3'd6, 8'h01);
        repeat (3) tick();
        chk_reg("len0_err", 3'd7, 8'h02);
        chk_reg("len0_status", 3'd6, 8'h04);
        check("len0_norun", 64'(run_cnt - n0), 64'd0);

        // Engine never raises BUSY.
        wr(3'd7, 8'h0F);
        wr(3'd4, 8'h02);
        wr(3'd6, 8'h01);
        wait_run();
        repeat (3) tick();
        chk_reg("tmo_err", 3'd7, 8'h02);
        chk_reg("tmo_idle", 3'd6, 8'h04);

        // W1C of all flags in the same cycle as a done pulse.
        wr(3'd6, 8'h01);
        wait_run();
        BUSY = 1'b1;
        tick(); tick();
        CS = 1'b1; WE = 1'b1; ADDR = 3'd7; DIN = 8'h0F; TRIG_DMAD = 1'b1;
        tick();
        CS = 1'b0; WE = 1'b0; DIN = 8'h00; TRIG_DMAD = 1'b0;
        chk_reg("w1c_done_wins", 3'd7, 8'h01);
        BUSY = 1'b0;
        repeat (3) tick();
        chk_reg("w1c_idle", 3'd6, 8'h04);

        // Abort while RUNNING with two more descriptors pushed.
        wr(3'd7, 8'h0F);
        wr(3'd6, 8'h01);
        wait_run();
        BUSY = 1'b1;
        tick(); tick();
        wr(3'd0, 8'h11); wr(3'd6, 8'h01);
        wr(3'd0, 8'h22); wr(3'd6, 8'h01);
        chk_reg("abt_queued", 3'd6, status_m(1'b0, 1'b1, (MD < 2) ? MD : 2, 1'b1));
        n0 = run_cnt;
        wr(3'd6, 8'h02);
        check("abt_run", 64'(RUN), 64'd1);
        check("abt_len0", 64'(LEN), 64'd0);
        chk_reg("abt_flushed", 3'd6, status_m(1'b0, 1'b1, 0, 1'b1));
        chk_reg("abt_flags", 3'd7, (MD < 2) ? 8'h0C : 8'h08);
        tick();
        check("abt_run_pulse", 64'(RUN), 64'd0);
        tick();
        BUSY = 1'b0;
        tick(); tick();
        chk_reg("abt_idle", 3'd6, 8'h04);
        repeat (5) tick();
        check("abt_one_run", 64'(run_cnt - n0), 64'd1);
        wr(3'd7, 8'h0F);

        // Randomized stalled bursts against the queue model.
        for (int r = 0; r < 24; r++) begin
            int n;
            int nrun;
            int ra;
            logic [3:0] fl;
            n  = (r == 0) ? 5 : int'($urandom_range(1, 6));
            fl = 4'd0;
            q_m.delete();
            BUSY = 1'b1;
            tick();
            for (int p = 0; p < n; p++) begin
                for (int a = 0; a < 6; a++)
                    if (r == 0 || $urandom_range(0, 1) == 1) wr(3'(a), 8'($urandom));
                if (r != 0 && $urandom_range(0, 5) == 0) wr(3'd4, 8'h00);
                else if (stg[4] == 8'h00) wr(3'd4, 8'($urandom_range(1, 255)));
                if (stg[4] == 8'h00) fl[1] = 1'b1;
                else if (q_m.size() == MD) fl[2] = 1'b1;
                else q_m.push_back(stg_desc());
                wr(3'd6, 8'h01);
            end
            chk_reg($sformatf("rnd%0d_status", r), 3'd6, status_m(1'b0, 1'b0, q_m.size(), 1'b1));
            chk_reg($sformatf("rnd%0d_flags", r), 3'd7, {4'd0, fl});
            ra = int'($urandom_range(0, 5));
            chk_reg($sformatf("rnd%0d_stg", r), 3'(ra), stg[ra]);
            nrun = q_m.size();
            BUSY = 1'b0;
            while (q_m.size() > 0) serve(q_m.pop_front(), int'($urandom_range(3, 6)));
            if (nrun > 0) fl[0] = 1'b1;
            n0 = run_cnt;
            repeat (6) tick();
            check($sformatf("rnd%0d_norun", r), 64'(run_cnt - n0), 64'd0);
            chk_reg($sformatf("rnd%0d_flags_end", r), 3'd7, {4'd0, fl});
            chk_reg($sformatf("rnd%0d_idle", r), 3'd6, 8'h04);
            wr(3'd7, 8'h0F);
            chk_reg($sformatf("rnd%0d_clr", r), 3'd7, 8'h00);
        end

        // Asynchronous reset during the RUN cycle.
        wr(3'd4, 8'h00);
        wr(3'd6, 8'h01);
        wr(3'd6, 8'h80);
        tick(); tick();
        check("pre_rst_irq", 64'(IRQ), 64'd1);
        wr(3'd4, 8'h05);
        wr(3'd6, 8'h81);
        wait_run();
        #2;
        RST = 1'b0;
        #1;
        check("arst_run", 64'(RUN), 64'd0);
        check("arst_desc", 64'({SRC, DST, LEN, INC}), 64'd0);
        check("arst_irq", 64'(IRQ), 64'd0);
        stg = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        chk_reg("arst_status", 3'd6, 8'h04);
        chk_reg("arst_flags", 3'd7, 8'h00);
        chk_reg("arst_inc", 3'd5, 8'h01);
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) tick();
        check("post_rst_run", 64'(RUN), 64'd0);
        chk_reg("post_rst_status", 3'd6, 8'h04);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
